uni2bi_conv: RTL and testbench
==============================

# uni2bi_conv

Unipolar-to-bipolar stochastic stream converter, the encode-side counterpart of the bipolar-to-unipolar stage in the shuffle stream library. It takes LANES parallel unipolar bitstreams (value v = P(1)) and emits bitstreams whose bipolar value equals v, i.e. P(out=1) = (v+1)/2. Each lane uses a small difference accumulator. A valid/ready skid-free output register and a frame counter let it sit between stream generators and downstream bipolar arithmetic blocks.

## Interface
- DEP, 3: accumulator width per lane; legal range is DEP >= 2.
- LANES, 1: number of independent parallel streams.
- FLEN, 256: transfers per frame; legal range is FLEN >= 2. The counter width is FW = $clog2(FLEN).
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active high.
- in_vld  in  1  input bit-vector valid.
- in_rdy  out  1  block can accept input this cycle.
- in  in  LANES  unipolar input bits, one per lane.
- frm_clr  in  1  synchronous clear of accumulators and frame counter.
- out_vld  out  1  output register holds valid data.
- out_rdy  in  1  downstream accepts output this cycle.
- out  out  LANES  bipolar output bits.
- out_last  out  1  flags the final output of a frame.

## Operation
- MID = 2^(DEP-1). Each lane i holds acc[i] (DEP bits). Its reset and clear value is MID.
- Transfer (xfer) = in_vld & in_rdy.
- Decision per lane: d[i] = acc[i][DEP-1], i.e. d[i] = 1 when acc[i] >= MID. It depends only on the current accumulator, not on in.
- Accumulator update on xfer: acc[i] <= acc[i] + in[i] + 1 - 2*d[i], computed at DEP+1 bits and truncated.
  - The accumulator provably stays in [MID-1, MID+1], so no saturation logic is needed.
  - Under sustained p = v, the long-run output mean is (v+1)/2.
- Without xfer, acc holds.
- Output register:
  - On xfer: out <= d, out_vld <= 1, and out_last <= (fcnt == FLEN-1).
  - Else if out_rdy: out_vld <= 0, and out/out_last hold their stale values.
- in_rdy = ~out_vld | out_rdy (combinational).
- Frame counter fcnt (FW bits), on xfer:
  - If fcnt == FLEN-1: fcnt <= 0 and all acc <= MID. This overrides the normal update, so each frame starts aligned.
  - Else: fcnt <= fcnt + 1.
- frm_clr:
  - Forces all acc <= MID and fcnt <= 0 at the next edge, whether or not xfer occurs.
  - If it coincides with xfer, the output still loads the decision from the pre-clear acc. out_last for that transfer uses the pre-clear fcnt. The clear then overrides the accumulator update.
- Lanes are fully independent except for the shared handshake and frame counter.

## Timing
- Reset (rst=1 at an edge):
  - acc = MID, fcnt = 0.
  - out_vld = 0, out = 0, out_last = 0.
  - in_rdy = 1 combinationally during and after reset.
- Latency: an input accepted at edge k appears on out with out_vld=1 after edge k. The decision uses acc before edge k.
- Throughput: one vector per cycle when out_rdy is held high.
- Backpressure (out_vld=1, out_rdy=0):
  - in_rdy = 0 and no xfer occurs.
  - out, out_last and out_vld hold stable.
  - acc and fcnt hold.
  - No bit is lost or duplicated.
- Simultaneous out_rdy=1 and in_vld=1 with out_vld=1: the old output is consumed and the new one is loaded at the same edge.
- Reset mid-operation: all state returns to reset values at that edge, and any pending output is dropped.
- rst has priority over frm_clr. frm_clr has priority over the frame-wrap and accumulator update.

## Test plan
- Reset, then in=0 every cycle with out_rdy=1 -> out_vld rises 1 cycle after the first xfer; out sequence is 1,0,1,0,... (bipolar 0).
- in=1 for 16 transfers -> out = 1 on all 16; acc stays at MID throughout.
- LANES=2, lane0 in p=0.25 (every 4th bit 1), lane1 in=0, 256 transfers -> lane0 ones count = 160±1, lane1 = 128±1; out_last pulses once, on the 256th output.
- Alternating out_rdy 0/1 with a random in_vld and a checked reference model -> the output sequence matches the zero-stall run bit-exactly; out is stable while out_vld & ~out_rdy; in_rdy = ~out_vld | out_rdy every cycle.
- FLEN=8, in=0 -> out_last=1 on the 8th output only; the 9th output = 1 (acc back at MID). frm_clr asserted with the 3rd xfer -> the 3rd output comes from the pre-clear acc, the 4th output = 1, and out_last next occurs 8 transfers after the clear.
- Assert rst for 1 cycle while out_vld=1 and out_rdy=0 -> next cycle out_vld=0, out=0, out_last=0, in_rdy=1; the subsequent sequence restarts exactly as from power-on.

Source files
------------

// File: rtl/uni2bi_conv.sv
// Unipolar-to-bipolar stochastic stream converter: per-lane difference accumulator, registered valid/ready output, frame counter.
// Latency: one cycle from input transfer to out_vld. Backpressure: in_rdy = ~out_vld | out_rdy; a stall freezes all state.
// Input and output share one output register stage; a new vector loads in the same edge the old one is consumed.
module uni2bi_conv #(
    parameter int DEP   = 3,
    parameter int LANES = 1,
    parameter int FLEN  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [LANES-1:0] in,
    input  logic             frm_clr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [LANES-1:0] out,
    output logic             out_last
);

    localparam int             FW   = $clog2(FLEN);
    localparam logic [DEP-1:0] MID  = {1'b1, {(DEP-1){1'b0}}};
    localparam logic [FW-1:0]  LAST = FW'(FLEN - 1);

    logic [LANES-1:0] dec;
    logic [FW-1:0]    fcnt;
    logic             xfer;
    logic             wrap;
    logic             acc_rld;

    assign in_rdy  = ~out_vld | out_rdy;
    assign xfer    = in_vld & in_rdy;
    assign wrap    = (fcnt == LAST);
    // Clear and frame wrap both take precedence over the normal accumulator step.
    assign acc_rld = frm_clr | (xfer & wrap);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DEP-1:0] acc;
        logic [DEP-1:0] acc_nxt;

        assign dec[g]  = acc[DEP-1];
        // Modulo-2^DEP arithmetic gives the same truncated result as a DEP+1 bit sum.
        assign acc_nxt = acc + DEP'(in[g]) + DEP'(1) - DEP'({dec[g], 1'b0});

        always_ff @(posedge clk) begin
            if (rst || acc_rld) begin
                acc <= MID;
            end else if (xfer) begin
                acc <= acc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || acc_rld) begin
            fcnt <= '0;
        end else if (xfer) begin
            fcnt <= fcnt + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out      <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            out_vld  <= 1'b1;
            out      <= dec;
            out_last <= wrap;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uni2bi_conv.sv
// Bench for uni2bi_conv: two instances (FLEN=256 and FLEN=8, two lanes each) share stimulus.
// Reference: a lane emits 1 while ones_out*2 <= ones_in + transfers since frame start.
module tb_uni2bi_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [1:0] in_bits;
    logic       frm_clr;
    logic       out_rdy;

    logic [1:0]      o_rdy, o_vld, o_last;
    logic [1:0][1:0] o_out;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    uni2bi_conv #(.DEP(3), .LANES(2), .FLEN(256)) dut_a (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(o_rdy[0]), .in(in_bits),
        .frm_clr(frm_clr), .out_vld(o_vld[0]), .out_rdy(out_rdy), .out(o_out[0]),
        .out_last(o_last[0])
    );

    uni2bi_conv #(.DEP(3), .LANES(2), .FLEN(8)) dut_b (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(o_rdy[1]), .in(in_bits),
        .frm_clr(frm_clr), .out_vld(o_vld[1]), .out_rdy(out_rdy), .out(o_out[1]),
        .out_last(o_last[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state, per instance k and lane l.
    int         flen [2] = '{256, 8};
    int         m_n  [2];
    int         m_s  [2][2];
    int         m_o  [2][2];
    bit         e_vld[2];
    logic [1:0] e_out[2];
    bit         e_last[2];
    bit         hold_prev[2];
    logic [1:0] held_out[2];
    bit         held_last[2];

    logic [1:0] lo_a[$], lo_b[$];
    bit         ll_a[$], ll_b[$];

    task automatic model_clear(input int k);
        m_n[k] = 0;
        for (int l = 0; l < 2; l++) begin
            m_s[k][l] = 0;
            m_o[k][l] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (hold_prev[k]) begin
                    chk("stall_vld", o_vld[k], 1);
                    chk("stall_out", o_out[k], held_out[k]);
                    chk("stall_last", o_last[k], held_last[k]);
                end
                chk("in_rdy", o_rdy[k], int'(!e_vld[k] || out_rdy));
                chk("out_vld", o_vld[k], e_vld[k]);
                if (e_vld[k]) begin
                    chk("out", o_out[k], e_out[k]);
                    chk("out_last", o_last[k], e_last[k]);
                end
                if (o_vld[k] && out_rdy) begin
                    if (k == 0) begin lo_a.push_back(o_out[k]); ll_a.push_back(o_last[k]); end
                    else        begin lo_b.push_back(o_out[k]); ll_b.push_back(o_last[k]); end
                end
                hold_prev[k] = o_vld[k] && !out_rdy && !rst;
                held_out[k]  = o_out[k];
                held_last[k] = o_last[k];

                if (rst) begin
                    model_clear(k);
                    e_vld[k] = 0; e_out[k] = '0; e_last[k] = 0;
                end else if (in_vld && (!e_vld[k] || out_rdy)) begin
                    logic [1:0] d;
                    for (int l = 0; l < 2; l++)
                        d[l] = (m_s[k][l] + m_n[k] >= 2 * m_o[k][l]);
                    e_out[k]  = d;
                    e_vld[k]  = 1;
                    e_last[k] = (m_n[k] == flen[k] - 1);
                    if (frm_clr || m_n[k] == flen[k] - 1) begin
                        model_clear(k);
                    end else begin
                        m_n[k]++;
                        for (int l = 0; l < 2; l++) begin
                            m_s[k][l] += int'(in_bits[l]);
                            m_o[k][l] += int'(d[l]);
                        end
                    end
                end else begin
                    if (out_rdy) e_vld[k] = 0;
                    if (frm_clr) model_clear(k);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1; in_vld = 0; frm_clr = 0; out_rdy = 1; in_bits = '0;
        tick();
        rst = 0;
        lo_a.delete(); lo_b.delete(); ll_a.delete(); ll_b.delete();
    endtask

    task automatic run_const(input logic [1:0] v, input int cnt);
        in_bits = v; in_vld = 1; out_rdy = 1; frm_clr = 0;
        for (int i = 0; i < cnt; i++) tick();
        in_vld = 0;
        tick();
    endtask

    initial begin
        int ones0, ones1, lasts;
        rst = 1; in_vld = 0; frm_clr = 0; out_rdy = 1; in_bits = '0;
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            e_vld[k] = 0; e_out[k] = '0; e_last[k] = 0; hold_prev[k] = 0;
        end
        tick();
        mon_en = 1;
        chk("rst_in_rdy", o_rdy[0], 1);
        chk("rst_out", o_out[0], 0);
        chk("rst_last", o_last[1], 0);
        restart();

        // in=0: alternating 1,0,...; FLEN=8 instance marks the 8th and restarts at 1.
        run_const(2'b00, 9);
        chk("pA_cnt_b", lo_b.size(), 9);
        if (lo_b.size() == 9)
            for (int i = 0; i < 9; i++) begin
                chk("pA_out_b", lo_b[i], (i % 2 == 0) ? 3 : 0);
                chk("pA_last_b", ll_b[i], int'(i == 7));
            end
        chk("pA_cnt_a", lo_a.size(), 9);
        if (lo_a.size() == 9)
            for (int i = 0; i < 8; i++) chk("pA_out_a", lo_a[i], (i % 2 == 0) ? 3 : 0);

        // in=1: every output 1.
        restart();
        run_const(2'b11, 16);
        chk("pB_cnt", lo_a.size(), 16);
        foreach (lo_a[i]) chk("pB_out", lo_a[i], 3);

        // lane0 p=0.25, lane1 p=0 over one full FLEN=256 frame.
        restart();
        out_rdy = 1; in_vld = 1;
        for (int i = 0; i < 256; i++) begin
            in_bits = {1'b0, (i % 4 == 3)};
            tick();
        end
        in_vld = 0;
        tick();
        ones0 = 0; ones1 = 0; lasts = 0;
        foreach (lo_a[i]) begin
            ones0 += int'(lo_a[i][0]);
            ones1 += int'(lo_a[i][1]);
            lasts += int'(ll_a[i]);
        end
        chk("pC_cnt", lo_a.size(), 256);
        chk("pC_ones0_in_160pm1", int'(ones0 >= 159 && ones0 <= 161), 1);
        chk("pC_ones1_in_128pm1", int'(ones1 >= 127 && ones1 <= 129), 1);
        chk("pC_lasts", lasts, 1);
        if (ll_a.size() == 256) chk("pC_last_pos", ll_a[255], 1);

        // frm_clr with the 3rd transfer on the FLEN=8 instance.
        restart();
        in_bits = 2'b00; out_rdy = 1; in_vld = 1;
        for (int i = 0; i < 12; i++) begin
            frm_clr = (i == 2);
            tick();
        end
        frm_clr = 0; in_vld = 0;
        tick();
        chk("pD_cnt", lo_b.size(), 12);
        if (lo_b.size() == 12)
            for (int j = 0; j < 12; j++) begin
                chk("pD_out", lo_b[j][0], (j < 3) ? int'(j % 2 == 0) : int'((j - 3) % 2 == 0));
                chk("pD_last", ll_b[j], int'(j == 10));
            end

        // Random traffic with stalls and occasional clears against the model.
        restart();
        for (int i = 0; i < 3000; i++) begin
            in_vld  = ($urandom_range(0, 9) < 7);
            in_bits = 2'($urandom_range(0, 3));
            out_rdy = (i < 1500) ? i[0] : 1'($urandom_range(0, 1));
            frm_clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        frm_clr = 0;

        // Reset while holding a stalled output.
        restart();
        in_bits = 2'b00; in_vld = 1; out_rdy = 0;
        tick();
        tick();
        chk("pF_stalled_vld", o_vld[0], 1);
        rst = 1; in_vld = 0;
        tick();
        rst = 0;
        chk("pF_vld", o_vld[0], 0);
        chk("pF_out", o_out[0], 0);
        chk("pF_last", o_last[0], 0);
        chk("pF_rdy", o_rdy[0], 1);
        lo_a.delete(); lo_b.delete(); ll_a.delete(); ll_b.delete();
        run_const(2'b00, 4);
        chk("pF_cnt", lo_a.size(), 4);
        foreach (lo_a[i]) chk("pF_seq", lo_a[i], (i % 2 == 0) ? 3 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
